// File: rtl/alu_result_fifo.sv
// First-word-fall-through FIFO for ALU results {out1, out2, cout, zero}.
// The head entry is presented from registers; reads are forced to zero while empty.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [7:0]    out1,
  input  logic [7:0]    out2,
  input  logic          cout,
  input  logic          clr,
  input  logic          out_ready,
  output logic [7:0]    res1,
  output logic [7:0]    res2,
  output logic          res_cout,
  output logic          res_zero,
  output logic          out_valid,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [7:0] r1;
    logic [7:0] r2;
    logic       c;
    logic       z;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          is_empty, is_full, push, pop;
  entry_t        wr_entry, head;

  always_comb begin
    is_empty = (count_q == '0);
    is_full  = (count_q == CW'(DEPTH));
    pop      = out_ready && !is_empty;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    push     = in_valid && (!is_full || pop);
    wr_entry = '{r1: out1, r2: out2, c: cout, z: (out1 == 8'h00)};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      if (in_valid && !push) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is deliberately unreset; the empty gate below hides stale data.
  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wr_ptr_q] <= wr_entry;
  end

  always_comb begin
    head      = is_empty ? '0 : mem_q[rd_ptr_q];
    res1      = head.r1;
    res2      = head.r2;
    res_cout  = head.c;
    res_zero  = head.z;
    out_valid = !is_empty;
    full      = is_full;
    empty     = is_empty;
    count     = count_q;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed vector table, reset corner sequence and a randomized queue-model run
// for alu_result_fifo at DEPTH=4.
module tb_alu_result_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] out1 = '0;
  logic [7:0] out2 = '0;
  logic       cout = 1'b0;
  logic       clr = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] res1, res2;
  logic       res_cout, res_zero, out_valid, full, empty, ovf;
  logic [2:0] count;

  int n_checks = 0;
  int n_errors = 0;

  alu_result_fifo #(.DEPTH(4), .CW(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .out1(out1), .out2(out2),
    .cout(cout), .clr(clr), .out_ready(out_ready), .res1(res1), .res2(res2),
    .res_cout(res_cout), .res_zero(res_zero), .out_valid(out_valid),
    .full(full), .empty(empty), .count(count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  logic [24:0] act;
  assign act = {res1, res2, res_cout, res_zero, out_valid, full, empty, count, ovf};

  // Expected output bundle; flags derived from the expected count.
  function automatic logic [24:0] ex(input logic [7:0] r1, input logic [7:0] r2,
                                     input logic c, input logic z,
                                     input int cnt, input logic o);
    logic [2:0] cv;
    cv = 3'(cnt);
    return {r1, r2, c, z, (cnt != 0), (cnt == 4), (cnt == 0), cv, o};
  endfunction

  task automatic check(input string name, input logic [24:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [7:0] o1, input logic [7:0] o2,
                      input logic c, input logic cl, input logic rdy);
    in_valid = iv; out1 = o1; out2 = o2; cout = c; clr = cl; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        iv;
    logic [7:0]  o1;
    logic [7:0]  o2;
    logic        c;
    logic        cl;
    logic        rdy;
    logic [24:0] exp;
  } vec_t;

  vec_t vt[18];

  initial begin
    // Directed table: inputs applied before an edge, outputs checked after it.
    vt[0]  = '{1, 8'h3C, 8'h01, 1, 0, 0, ex(8'h3C, 8'h01, 1, 0, 1, 0)};
    vt[1]  = '{0, 8'h00, 8'h00, 0, 0, 1, ex(8'h00, 8'h00, 0, 0, 0, 0)};
    vt[2]  = '{1, 8'h00, 8'h77, 0, 0, 0, ex(8'h00, 8'h77, 0, 1, 1, 0)};
    vt[3]  = '{0, 8'h00, 8'h00, 0, 0, 1, ex(8'h00, 8'h00, 0, 0, 0, 0)};
    vt[4]  = '{0, 8'h00, 8'h00, 0, 0, 1, ex(8'h00, 8'h00, 0, 0, 0, 0)};
    vt[5]  = '{1, 8'h10, 8'hA0, 0, 0, 0, ex(8'h10, 8'hA0, 0, 0, 1, 0)};
    vt[6]  = '{1, 8'h11, 8'hA1, 1, 0, 0, ex(8'h10, 8'hA0, 0, 0, 2, 0)};
    vt[7]  = '{1, 8'h12, 8'hA2, 0, 0, 0, ex(8'h10, 8'hA0, 0, 0, 3, 0)};
    vt[8]  = '{1, 8'h13, 8'hA3, 1, 0, 0, ex(8'h10, 8'hA0, 0, 0, 4, 0)};
    vt[9]  = '{1, 8'h14, 8'hA4, 0, 0, 0, ex(8'h10, 8'hA0, 0, 0, 4, 1)};
    vt[10] = '{1, 8'hAA, 8'hBB, 1, 0, 1, ex(8'h11, 8'hA1, 1, 0, 4, 1)};
    vt[11] = '{0, 8'h00, 8'h00, 0, 0, 1, ex(8'h12, 8'hA2, 0, 0, 3, 1)};
    vt[12] = '{0, 8'h00, 8'h00, 0, 0, 1, ex(8'h13, 8'hA3, 1, 0, 2, 1)};
    vt[13] = '{0, 8'h00, 8'h00, 0, 0, 1, ex(8'hAA, 8'hBB, 1, 0, 1, 1)};
    vt[14] = '{1, 8'h20, 8'h21, 0, 0, 1, ex(8'h20, 8'h21, 0, 0, 1, 1)};
    vt[15] = '{1, 8'h30, 8'h31, 1, 1, 1, ex(8'h00, 8'h00, 0, 0, 0, 0)};
    vt[16] = '{1, 8'h05, 8'h06, 1, 0, 1, ex(8'h05, 8'h06, 1, 0, 1, 0)};
    vt[17] = '{0, 8'h00, 8'h00, 0, 1, 0, ex(8'h00, 8'h00, 0, 0, 0, 0)};

    #12;
    check("reset_state", ex(8'h00, 8'h00, 0, 0, 0, 0));
    $display("reset: outputs %h", act);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++) begin
      step(vt[i].iv, vt[i].o1, vt[i].o2, vt[i].c, vt[i].cl, vt[i].rdy);
      check($sformatf("vec%0d", i), vt[i].exp);
      $display("vec %0d: iv=%0b o1=%h clr=%0b rdy=%0b -> %h", i, vt[i].iv, vt[i].o1,
               vt[i].cl, vt[i].rdy, act);
    end

    // Asynchronous reset between edges with three entries loaded.
    step(1, 8'h01, 8'h02, 0, 0, 0);
    step(1, 8'h03, 8'h04, 1, 0, 0);
    step(1, 8'h05, 8'h06, 0, 0, 0);
    check("loaded3", ex(8'h01, 8'h02, 0, 0, 3, 0));
    $display("seq: loaded 3 -> %h", act);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", ex(8'h00, 8'h00, 0, 0, 0, 0));
    $display("seq: async reset -> %h", act);
    #1 rst_n = 1'b1;
    step(1, 8'h55, 8'h66, 0, 0, 0);
    check("after_reset_push", ex(8'h55, 8'h66, 0, 0, 1, 0));
    $display("seq: push 55 after reset -> %h", act);
    step(0, 8'h00, 8'h00, 0, 1, 0);
    check("clr_final", ex(8'h00, 8'h00, 0, 0, 0, 0));

    // Randomized traffic against a reference queue.
    begin
      logic [17:0] q[$];
      logic        m_ovf;
      logic        iv, rdy, cl, c, m_pop, m_push;
      logic [7:0]  o1, o2;
      logic [24:0] e;
      int          start_err;
      m_ovf = 1'b0;
      start_err = n_errors;
      for (int cyc = 0; cyc < 10000; cyc++) begin
        iv  = ($urandom_range(0, 9) < 6);
        rdy = ($urandom_range(0, 1) == 1);
        cl  = ($urandom_range(0, 63) == 0);
        o1  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        o2  = 8'($urandom);
        c   = 1'($urandom);
        m_pop  = rdy && (q.size() > 0);
        m_push = iv && ((q.size() < 4) || m_pop);
        if (cl) begin
          q.delete();
          m_ovf = 1'b0;
        end else begin
          if (m_pop) void'(q.pop_front());
          if (m_push) q.push_back({o1, o2, c, (o1 == 8'h00)});
          if (iv && !m_push) m_ovf = 1'b1;
        end
        step(iv, o1, o2, c, cl, rdy);
        if (q.size() > 0)
          e = ex(q[0][17:10], q[0][9:2], q[0][1], q[0][0], q.size(), m_ovf);
        else
          e = ex(8'h00, 8'h00, 0, 0, 0, m_ovf);
        check($sformatf("rand%0d", cyc), e);
      end
      $display("random: 10000 cycles, %0d errors", n_errors - start_err);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 Parameter DEPTH, default 4, number of result entries (power of two, 2..16).
REQ-002 Parameter CW, default 3, occupancy counter width, equals log2(DEPTH)+1.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  ALU result present this cycle; push request.
REQ-006 out1  input  8  ALU primary result.
REQ-007 out2  input  8  ALU secondary result.
REQ-008 cout  input  1  ALU carry/borrow out.
REQ-009 clr  input  1  synchronous flush of contents and sticky flag.
REQ-010 out_ready  input  1  consumer accepts head entry this cycle.
REQ-011 res1  output  8  head entry out1.
REQ-012 res2  output  8  head entry out2.
REQ-013 res_cout  output  1  head entry cout.
REQ-014 res_zero  output  1  head entry flag: 1 iff stored out1 == 8'h00.
REQ-015 out_valid  output  1  head entry valid; equals !empty.
REQ-016 full  output  1  count == DEPTH.
REQ-017 empty  output  1  count == 0.
REQ-018 count  output  CW  number of stored entries, 0..DEPTH.
REQ-019 ovf  output  1  sticky: a push was dropped.

Function
REQ-020 Each entry SHALL store {out1, out2, cout, zero}, 18 bits; zero computed from out1 at push time.
REQ-021 Push SHALL occur on a rising edge when in_valid=1 and (full=0 or pop occurs same edge).
REQ-022 Pop SHALL occur on a rising edge when out_ready=1 and out_valid=1; out_ready with empty FIFO is ignored.
REQ-023 Storage SHALL be first-word-fall-through: head entry presented on res* from registers, no read latency.
REQ-024 Latency SHALL be one clock: entry pushed at edge N is visible with out_valid=1 after edge N when FIFO was empty.
REQ-025 Entries SHALL leave in push order; read/write pointers SHALL wrap modulo DEPTH.
REQ-026 Simultaneous push and pop SHALL leave count unchanged, including when full (write accepted) and when count=1.
REQ-027 Push and pop when empty SHALL act as push only; count becomes 1.
REQ-028 Push when full without pop SHALL be dropped, contents unchanged, ovf set to 1 at that edge.
REQ-029 ovf SHALL remain 1 until reset or clr.
REQ-030 clr=1 SHALL at the edge set count=0, pointers=0, ovf=0, and discard any same-cycle push and pop.
REQ-031 res1/res2/res_cout/res_zero SHALL read 0 while empty.
REQ-032 count, full, empty, out_valid SHALL be registered or derived only from registered state; no combinational path from in_valid to any output.
REQ-033 out_ready SHALL have no combinational effect on outputs within the same cycle.

Reset
REQ-034 rst_n=0 SHALL immediately, without a clock, force count=0, pointers=0, empty=1, full=0, out_valid=0, ovf=0, res*=0.
REQ-035 Reset asserted mid-operation SHALL discard all stored entries; the first edge after rst_n rises SHALL behave as from empty.
REQ-036 Storage array contents need not be reset; they SHALL never be observable while empty.

Verification
REQ-037 Push out1=8'h3C,out2=8'h01,cout=1 into empty FIFO -> next cycle out_valid=1,res1=8'h3C,res2=8'h01,res_cout=1,res_zero=0,count=1.
REQ-038 Push out1=8'h00 then pop -> res_zero=1 while head; after pop empty=1, res*=0.
REQ-039 Push 5 entries 8'h10..8'h14 with out_ready=0 at DEPTH=4 -> full=1, count=4, ovf=1; popping yields 10,11,12,13 in order, then empty.
REQ-040 While full, push 8'hAA and pop same edge -> count stays 4, ovf unchanged, 8'hAA emerges last after 3 more pops.
REQ-041 Load 3 entries, assert rst_n=0 between edges -> outputs zero immediately; after release, one push 8'h55 -> count=1, res1=8'h55.
REQ-042 Random in_valid/out_ready for 10000 cycles against a reference queue model -> order, count, full/empty, ovf match every cycle.
